// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: XLEN, major opcodes, immediate formats and
// per-opcode operand/destination usage.
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    // What an opcode does with the register file. writes_rd ignores the
    // rd == x0 case; the stage folds that in separately.
    typedef struct packed {
        logic legal;
        logic rs1_used;
        logic rs2_used;
        logic writes_rd;
    } opc_class_t;

    function automatic imm_fmt_e opcode_imm_fmt(input logic [6:0] opcode);
        imm_fmt_e fmt;
        case (opcode)
            OPC_JALR, OPC_LOAD, OPC_OP_IMM,
            OPC_MISC_MEM, OPC_SYSTEM:        fmt = IMM_I;
            OPC_STORE:                       fmt = IMM_S;
            OPC_BRANCH:                      fmt = IMM_B;
            OPC_LUI, OPC_AUIPC:              fmt = IMM_U;
            OPC_JAL:                         fmt = IMM_J;
            default:                         fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

    function automatic opc_class_t opcode_class(input logic [6:0] opcode);
        opc_class_t c;
        c = '0;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                c.legal     = 1'b1;
                c.writes_rd = 1'b1;
            end
            OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
                c.legal     = 1'b1;
                c.rs1_used  = 1'b1;
                c.writes_rd = 1'b1;
            end
            OPC_OP: begin
                c.legal     = 1'b1;
                c.rs1_used  = 1'b1;
                c.rs2_used  = 1'b1;
                c.writes_rd = 1'b1;
            end
            OPC_STORE, OPC_BRANCH: begin
                c.legal     = 1'b1;
                c.rs1_used  = 1'b1;
                c.rs2_used  = 1'b1;
            end
            OPC_MISC_MEM, OPC_SYSTEM: begin
                c.legal     = 1'b1;
                c.rs1_used  = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator. Unknown opcodes and R-type
// produce zero; everything else is sign-extended from instr bit 31.
module imm_gen
    import riscv_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [31:0] imm_o
);

    logic     sign;
    imm_fmt_e fmt;

    assign sign = instr_i[31];
    assign fmt  = opcode_imm_fmt(instr_i[6:0]);

    // Reassemble the immediate bits scattered by each encoding format.
    always_comb begin
        imm_o = '0;
        case (fmt)
            IMM_I: imm_o = {{20{sign}}, instr_i[31:20]};
            IMM_S: imm_o = {{20{sign}}, instr_i[31:25], instr_i[11:7]};
            IMM_B: imm_o = {{19{sign}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U: imm_o = {instr_i[31:12], 12'b0};
            IMM_J: imm_o = {{11{sign}}, instr_i[31], instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0};
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode / operand-fetch stage. Register file addresses come straight
// off instr_i; a busy bit per register holds back any instruction that would
// read or overwrite a register still waiting on its writeback.
module decode_stage
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,

    input  logic        instr_valid_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic        instr_ready_o,

    output logic [4:0]  rs1_addr_o,
    output logic [4:0]  rs2_addr_o,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,

    input  logic        wb_valid_i,
    input  logic [4:0]  wb_addr_i,

    input  logic        flush_i,

    output logic        ex_valid_o,
    input  logic        ex_ready_i,
    output logic [31:0] ex_pc_o,
    output logic [31:0] ex_rs1_o,
    output logic [31:0] ex_rs2_o,
    output logic [31:0] ex_imm_o,
    output logic [4:0]  ex_rd_o,
    output logic [6:0]  ex_opcode_o,
    output logic [2:0]  ex_funct3_o,
    output logic        ex_funct7b5_o,
    output logic        ex_rd_we_o,
    output logic        ex_illegal_o
);

    // ------------------------------------------------------------------
    // Decode of the incoming instruction
    // ------------------------------------------------------------------
    logic [6:0]      dec_opcode;
    logic [4:0]      dec_rd;
    logic [4:0]      dec_rs1;
    logic [4:0]      dec_rs2;
    logic [2:0]      dec_funct3;
    logic            dec_funct7b5;
    logic [XLEN-1:0] dec_imm;
    opc_class_t      dec_class;
    logic            dec_rd_we;

    assign dec_opcode   = instr_i[6:0];
    assign dec_rd       = instr_i[11:7];
    assign dec_funct3   = instr_i[14:12];
    assign dec_rs1      = instr_i[19:15];
    assign dec_rs2      = instr_i[24:20];
    assign dec_funct7b5 = instr_i[30];
    assign dec_class    = opcode_class(dec_opcode);
    assign dec_rd_we    = dec_class.writes_rd & (dec_rd != 5'd0);

    assign rs1_addr_o = dec_rs1;
    assign rs2_addr_o = dec_rs2;

    imm_gen u_imm_gen (
        .instr_i (instr_i),
        .imm_o   (dec_imm)
    );

    // ------------------------------------------------------------------
    // Scoreboard and handshake
    // ------------------------------------------------------------------
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] busy_set;
    logic [NREGS-1:0] busy_clr;

    logic ex_valid_q;
    logic ex_rd_we_q;
    logic [4:0] ex_rd_q;

    logic stall;
    logic accept;

    // x0 is never written, so its bit can never be busy.
    assign busy_set[0] = 1'b0;
    assign busy_clr[0] = 1'b0;

    // Per-register set on issue; clear on writeback or when the flushed
    // instruction that claimed the register is dropped.
    generate
        for (genvar gi = 1; gi < NREGS; gi++) begin : g_busy
            assign busy_set[gi] = accept & dec_rd_we & (dec_rd == 5'(gi));
            assign busy_clr[gi] = (wb_valid_i & (wb_addr_i == 5'(gi)))
                                | (flush_i & ex_valid_q & ex_rd_we_q
                                   & (ex_rd_q == 5'(gi)));
        end
    endgenerate

    // Hazard check and acceptance; set takes priority over clear.
    always_comb begin
        stall = (dec_class.rs1_used & busy_q[dec_rs1])
              | (dec_class.rs2_used & busy_q[dec_rs2])
              | (dec_rd_we          & busy_q[dec_rd]);
        instr_ready_o = ~flush_i & ~stall & (~ex_valid_q | ex_ready_i);
        accept        = instr_valid_i & instr_ready_o;
        busy_d        = busy_set | (busy_q & ~busy_clr);
        busy_d[0]     = 1'b0;
    end

    // Scoreboard state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Output pipeline register
    // ------------------------------------------------------------------
    logic        ex_valid_d;
    logic [31:0] ex_pc_q,  ex_pc_d;
    logic [31:0] ex_rs1_q, ex_rs1_d;
    logic [31:0] ex_rs2_q, ex_rs2_d;
    logic [31:0] ex_imm_q, ex_imm_d;
    logic [4:0]  ex_rd_d;
    logic [6:0]  ex_opcode_q, ex_opcode_d;
    logic [2:0]  ex_funct3_q, ex_funct3_d;
    logic        ex_funct7b5_q, ex_funct7b5_d;
    logic        ex_rd_we_d;
    logic        ex_illegal_q, ex_illegal_d;

    // Load on accept, drop on consume or flush, otherwise hold so execute
    // sees stable fields while it back-pressures.
    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_pc_d       = ex_pc_q;
        ex_rs1_d      = ex_rs1_q;
        ex_rs2_d      = ex_rs2_q;
        ex_imm_d      = ex_imm_q;
        ex_rd_d       = ex_rd_q;
        ex_opcode_d   = ex_opcode_q;
        ex_funct3_d   = ex_funct3_q;
        ex_funct7b5_d = ex_funct7b5_q;
        ex_rd_we_d    = ex_rd_we_q;
        ex_illegal_d  = ex_illegal_q;

        if (flush_i) begin
            ex_valid_d = 1'b0;
        end else if (accept) begin
            ex_valid_d    = 1'b1;
            ex_pc_d       = pc_i;
            ex_rs1_d      = rs1_i;
            ex_rs2_d      = rs2_i;
            ex_imm_d      = dec_imm;
            ex_rd_d       = dec_rd;
            ex_opcode_d   = dec_opcode;
            ex_funct3_d   = dec_funct3;
            ex_funct7b5_d = dec_funct7b5;
            ex_rd_we_d    = dec_rd_we;
            ex_illegal_d  = ~dec_class.legal;
        end else if (ex_ready_i) begin
            ex_valid_d = 1'b0;
        end
    end

    // Output register state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid_q    <= 1'b0;
            ex_pc_q       <= '0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            ex_imm_q      <= '0;
            ex_rd_q       <= '0;
            ex_opcode_q   <= '0;
            ex_funct3_q   <= '0;
            ex_funct7b5_q <= 1'b0;
            ex_rd_we_q    <= 1'b0;
            ex_illegal_q  <= 1'b0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_pc_q       <= ex_pc_d;
            ex_rs1_q      <= ex_rs1_d;
            ex_rs2_q      <= ex_rs2_d;
            ex_imm_q      <= ex_imm_d;
            ex_rd_q       <= ex_rd_d;
            ex_opcode_q   <= ex_opcode_d;
            ex_funct3_q   <= ex_funct3_d;
            ex_funct7b5_q <= ex_funct7b5_d;
            ex_rd_we_q    <= ex_rd_we_d;
            ex_illegal_q  <= ex_illegal_d;
        end
    end

    assign ex_valid_o    = ex_valid_q;
    assign ex_pc_o       = ex_pc_q;
    assign ex_rs1_o      = ex_rs1_q;
    assign ex_rs2_o      = ex_rs2_q;
    assign ex_imm_o      = ex_imm_q;
    assign ex_rd_o       = ex_rd_q;
    assign ex_opcode_o   = ex_opcode_q;
    assign ex_funct3_o   = ex_funct3_q;
    assign ex_funct7b5_o = ex_funct7b5_q;
    assign ex_rd_we_o    = ex_rd_we_q;
    assign ex_illegal_o  = ex_illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a behavioural register file supplies
// operand data; every expected value below is hand-decoded from the
// instruction encodings.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        instr_valid_i;
    logic [31:0] instr_i;
    logic [31:0] pc_i;
    logic        instr_ready_o;
    logic [4:0]  rs1_addr_o, rs2_addr_o;
    logic [31:0] rs1_i, rs2_i;
    logic        wb_valid_i;
    logic [4:0]  wb_addr_i;
    logic        flush_i;
    logic        ex_valid_o;
    logic        ex_ready_i;
    logic [31:0] ex_pc_o, ex_rs1_o, ex_rs2_o, ex_imm_o;
    logic [4:0]  ex_rd_o;
    logic [6:0]  ex_opcode_o;
    logic [2:0]  ex_funct3_o;
    logic        ex_funct7b5_o;
    logic        ex_rd_we_o;
    logic        ex_illegal_o;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] wb_data = '0;
    logic [31:0] rf [32] = '{default: 32'h0};

    always #5 clk = ~clk;

    // Register file model: write at the clock edge, asynchronous read.
    always @(posedge clk) begin
        if (wb_valid_i && wb_addr_i != 5'd0)
            rf[wb_addr_i] <= wb_data;
    end
    assign rs1_i = rf[rs1_addr_o];
    assign rs2_i = rf[rs2_addr_o];

    decode_stage dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .instr_valid_i (instr_valid_i),
        .instr_i       (instr_i),
        .pc_i          (pc_i),
        .instr_ready_o (instr_ready_o),
        .rs1_addr_o    (rs1_addr_o),
        .rs2_addr_o    (rs2_addr_o),
        .rs1_i         (rs1_i),
        .rs2_i         (rs2_i),
        .wb_valid_i    (wb_valid_i),
        .wb_addr_i     (wb_addr_i),
        .flush_i       (flush_i),
        .ex_valid_o    (ex_valid_o),
        .ex_ready_i    (ex_ready_i),
        .ex_pc_o       (ex_pc_o),
        .ex_rs1_o      (ex_rs1_o),
        .ex_rs2_o      (ex_rs2_o),
        .ex_imm_o      (ex_imm_o),
        .ex_rd_o       (ex_rd_o),
        .ex_opcode_o   (ex_opcode_o),
        .ex_funct3_o   (ex_funct3_o),
        .ex_funct7b5_o (ex_funct7b5_o),
        .ex_rd_we_o    (ex_rd_we_o),
        .ex_illegal_o  (ex_illegal_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] instr, input logic [31:0] pc);
        instr_valid_i = 1'b1;
        instr_i       = instr;
        pc_i          = pc;
        $display("[TB] present instr=%08h pc=%08h", instr, pc);
    endtask

    task automatic do_wb(input logic [4:0] addr, input logic [31:0] data);
        wb_valid_i = 1'b1;
        wb_addr_i  = addr;
        wb_data    = data;
        tick();
        wb_valid_i = 1'b0;
        $display("[TB] writeback x%0d=%08h", addr, data);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; instr_valid_i = 1'b0; instr_i = '0; pc_i = '0;
        wb_valid_i = 1'b0; wb_addr_i = '0; flush_i = 1'b0; ex_ready_i = 1'b1;
        tick(); tick();
        tests_run++; if (ex_valid_o !== 1'b0) begin tests_failed++;
            $display("FAIL reset_valid: got %b exp 0", ex_valid_o); end
        tests_run++; if ({ex_pc_o, ex_imm_o, ex_rs1_o} !== 96'h0) begin tests_failed++;
            $display("FAIL reset_data: got %h exp 0", {ex_pc_o, ex_imm_o, ex_rs1_o}); end
        tests_run++; if ({ex_rd_we_o, ex_illegal_o, ex_rd_o} !== 7'h0) begin tests_failed++;
            $display("FAIL reset_ctrl: got %h exp 0", {ex_rd_we_o, ex_illegal_o, ex_rd_o}); end
        tests_run++; if (instr_ready_o !== 1'b1) begin tests_failed++;
            $display("FAIL reset_ready: got %b exp 1", instr_ready_o); end
        reset_n = 1'b1;
        tick();
    endtask

    // ADDI x1,x0,5
    task automatic test_addi();
        present(32'h00500093, 32'h100);
        #1;
        tests_run++; if (instr_ready_o !== 1'b1) begin tests_failed++;
            $display("FAIL addi_ready: got %b exp 1", instr_ready_o); end
        tick();
        instr_valid_i = 1'b0;
        tests_run++; if (ex_valid_o !== 1'b1) begin tests_failed++;
            $display("FAIL addi_valid: got %b exp 1", ex_valid_o); end
        tests_run++; if (ex_rd_o !== 5'd1 || ex_rd_we_o !== 1'b1) begin tests_failed++;
            $display("FAIL addi_rd: got rd=%0d we=%b exp rd=1 we=1", ex_rd_o, ex_rd_we_o); end
        tests_run++; if (ex_imm_o !== 32'd5) begin tests_failed++;
            $display("FAIL addi_imm: got %h exp 00000005", ex_imm_o); end
        tests_run++; if (ex_opcode_o !== 7'h13 || ex_pc_o !== 32'h100 || ex_illegal_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL addi_fields: got op=%h pc=%h ill=%b exp op=13 pc=100 ill=0",
                     ex_opcode_o, ex_pc_o, ex_illegal_o); end
    endtask

    // ADD x2,x1,x1 must wait for x1 writeback, then read the new value.
    task automatic test_raw();
        present(32'h00108133, 32'h104);
        #1;
        tests_run++; if (rs1_addr_o !== 5'd1 || rs2_addr_o !== 5'd1) begin tests_failed++;
            $display("FAIL raw_addr: got %0d,%0d exp 1,1", rs1_addr_o, rs2_addr_o); end
        tests_run++; if (instr_ready_o !== 1'b0) begin tests_failed++;
            $display("FAIL raw_stall0: got %b exp 0", instr_ready_o); end
        tick();
        tests_run++; if (ex_valid_o !== 1'b0 || instr_ready_o !== 1'b0) begin tests_failed++;
            $display("FAIL raw_stall1: got valid=%b ready=%b exp 0,0", ex_valid_o, instr_ready_o); end
        wb_valid_i = 1'b1; wb_addr_i = 5'd1; wb_data = 32'hDEADBEEF;
        #1;
        tests_run++; if (instr_ready_o !== 1'b0) begin tests_failed++;
            $display("FAIL raw_nobypass: got %b exp 0", instr_ready_o); end
        tick();
        wb_valid_i = 1'b0;
        #1;
        tests_run++; if (instr_ready_o !== 1'b1) begin tests_failed++;
            $display("FAIL raw_release: got %b exp 1", instr_ready_o); end
        tick();
        instr_valid_i = 1'b0;
        tests_run++; if (ex_valid_o !== 1'b1 || ex_rd_o !== 5'd2 || ex_pc_o !== 32'h104) begin
            tests_failed++;
            $display("FAIL raw_issue: got v=%b rd=%0d pc=%h exp 1,2,104", ex_valid_o, ex_rd_o, ex_pc_o); end
        tests_run++; if (ex_rs1_o !== 32'hDEADBEEF || ex_rs2_o !== 32'hDEADBEEF) begin tests_failed++;
            $display("FAIL raw_operands: got %h,%h exp deadbeef,deadbeef", ex_rs1_o, ex_rs2_o); end
        tests_run++; if (ex_imm_o !== 32'h0 || ex_funct7b5_o !== 1'b0) begin tests_failed++;
            $display("FAIL raw_rtype: got imm=%h f7=%b exp 0,0", ex_imm_o, ex_funct7b5_o); end
        do_wb(5'd2, 32'h22);
    endtask

    // BEQ x0,x0,-8 then ADDI x6,x25,0 (rd field of BEQ is 25, must not be busy).
    task automatic test_branch();
        present(32'hFE000CE3, 32'h200);
        tick();
        tests_run++; if (ex_imm_o !== 32'hFFFFFFF8) begin tests_failed++;
            $display("FAIL beq_imm: got %h exp fffffff8", ex_imm_o); end
        tests_run++; if (ex_rd_we_o !== 1'b0 || ex_opcode_o !== 7'h63) begin tests_failed++;
            $display("FAIL beq_ctrl: got we=%b op=%h exp 0,63", ex_rd_we_o, ex_opcode_o); end
        present(32'h000C8313, 32'h204);
        #1;
        tests_run++; if (instr_ready_o !== 1'b1) begin tests_failed++;
            $display("FAIL beq_nobusy: got %b exp 1", instr_ready_o); end
        tick();
        instr_valid_i = 1'b0;
        tests_run++; if (ex_rd_o !== 5'd6 || ex_valid_o !== 1'b1) begin tests_failed++;
            $display("FAIL beq_next: got rd=%0d v=%b exp 6,1", ex_rd_o, ex_valid_o); end
        do_wb(5'd6, 32'h66);
    endtask

    // LUI x5,0x12345 held under back-pressure; ADDI x7,x0,1 waits.
    task automatic test_backpressure();
        present(32'h123452B7, 32'h300);
        tick();
        ex_ready_i = 1'b0;
        present(32'h00100393, 32'h304);
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++; if (instr_ready_o !== 1'b0) begin tests_failed++;
                $display("FAIL bp_ready[%0d]: got %b exp 0", i, instr_ready_o); end
            tests_run++; if (ex_valid_o !== 1'b1 || ex_imm_o !== 32'h12345000 || ex_rd_o !== 5'd5
                             || ex_pc_o !== 32'h300 || ex_opcode_o !== 7'h37) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: got v=%b imm=%h rd=%0d pc=%h op=%h exp 1,12345000,5,300,37",
                         i, ex_valid_o, ex_imm_o, ex_rd_o, ex_pc_o, ex_opcode_o); end
            tick();
        end
        ex_ready_i = 1'b1;
        #1;
        tests_run++; if (instr_ready_o !== 1'b1) begin tests_failed++;
            $display("FAIL bp_resume: got %b exp 1", instr_ready_o); end
        tick();
        instr_valid_i = 1'b0;
        tests_run++; if (ex_rd_o !== 5'd7 || ex_imm_o !== 32'd1 || ex_pc_o !== 32'h304) begin
            tests_failed++;
            $display("FAIL bp_next: got rd=%0d imm=%h pc=%h exp 7,1,304", ex_rd_o, ex_imm_o, ex_pc_o); end
        do_wb(5'd5, 32'h55);
        do_wb(5'd7, 32'h77);
    endtask

    // Flush ADDI x3 while held; ADDI x4,x3,0 must then issue without stall.
    task automatic test_flush();
        present(32'h00100193, 32'h400);
        tick();
        ex_ready_i = 1'b0;
        tests_run++; if (ex_valid_o !== 1'b1 || ex_rd_o !== 5'd3) begin tests_failed++;
            $display("FAIL flush_pre: got v=%b rd=%0d exp 1,3", ex_valid_o, ex_rd_o); end
        flush_i = 1'b1;
        present(32'h00018213, 32'h404);
        #1;
        tests_run++; if (instr_ready_o !== 1'b0) begin tests_failed++;
            $display("FAIL flush_ready: got %b exp 0", instr_ready_o); end
        tick();
        flush_i = 1'b0;
        #1;
        tests_run++; if (ex_valid_o !== 1'b0) begin tests_failed++;
            $display("FAIL flush_valid: got %b exp 0", ex_valid_o); end
        tests_run++; if (instr_ready_o !== 1'b1) begin tests_failed++;
            $display("FAIL flush_busy_clr: got %b exp 1", instr_ready_o); end
        tick();
        instr_valid_i = 1'b0;
        ex_ready_i = 1'b1;
        tests_run++; if (ex_valid_o !== 1'b1 || ex_rd_o !== 5'd4) begin tests_failed++;
            $display("FAIL flush_next: got v=%b rd=%0d exp 1,4", ex_valid_o, ex_rd_o); end
        do_wb(5'd4, 32'h44);
    endtask

    // Illegal opcode 0x7F, ADDI x0, then ADD x9,x0,x0.
    task automatic test_illegal_x0();
        present(32'h0000017F, 32'h500);
        tick();
        tests_run++; if (ex_illegal_o !== 1'b1 || ex_rd_we_o !== 1'b0 || ex_imm_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL ill_fields: got ill=%b we=%b imm=%h exp 1,0,0", ex_illegal_o, ex_rd_we_o, ex_imm_o); end
        present(32'h00100013, 32'h504);
        #1;
        tests_run++; if (instr_ready_o !== 1'b1) begin tests_failed++;
            $display("FAIL ill_nobusy: got %b exp 1", instr_ready_o); end
        tick();
        tests_run++; if (ex_illegal_o !== 1'b0 || ex_rd_we_o !== 1'b0 || ex_imm_o !== 32'd1) begin
            tests_failed++;
            $display("FAIL x0_write: got ill=%b we=%b imm=%h exp 0,0,1", ex_illegal_o, ex_rd_we_o, ex_imm_o); end
        present(32'h000004B3, 32'h508);
        #1;
        tests_run++; if (instr_ready_o !== 1'b1) begin tests_failed++;
            $display("FAIL x0_read: got %b exp 1", instr_ready_o); end
        tick();
        instr_valid_i = 1'b0;
        tests_run++; if (ex_rd_we_o !== 1'b1 || ex_rd_o !== 5'd9) begin tests_failed++;
            $display("FAIL add_x9: got we=%b rd=%0d exp 1,9", ex_rd_we_o, ex_rd_o); end
        do_wb(5'd9, 32'h99);
    endtask

    // SW x2,-4(x1); JAL x1,+8; AUIPC x13,1 issued on consecutive cycles.
    task automatic test_back_to_back();
        present(32'hFE20AE23, 32'h600);
        #1;
        tests_run++; if (instr_ready_o !== 1'b1) begin tests_failed++;
            $display("FAIL b2b_ready0: got %b exp 1", instr_ready_o); end
        tick();
        tests_run++; if (ex_imm_o !== 32'hFFFFFFFC || ex_rd_we_o !== 1'b0 || ex_funct3_o !== 3'd2
                         || ex_rs1_o !== 32'hDEADBEEF || ex_rs2_o !== 32'h22) begin
            tests_failed++;
            $display("FAIL b2b_sw: got imm=%h we=%b f3=%0d rs1=%h rs2=%h exp fffffffc,0,2,deadbeef,22",
                     ex_imm_o, ex_rd_we_o, ex_funct3_o, ex_rs1_o, ex_rs2_o); end
        present(32'h008000EF, 32'h604);
        #1;
        tests_run++; if (instr_ready_o !== 1'b1) begin tests_failed++;
            $display("FAIL b2b_ready1: got %b exp 1", instr_ready_o); end
        tick();
        tests_run++; if (ex_imm_o !== 32'd8 || ex_rd_we_o !== 1'b1 || ex_rd_o !== 5'd1 || ex_pc_o !== 32'h604) begin
            tests_failed++;
            $display("FAIL b2b_jal: got imm=%h we=%b rd=%0d pc=%h exp 8,1,1,604",
                     ex_imm_o, ex_rd_we_o, ex_rd_o, ex_pc_o); end
        present(32'h00001697, 32'h608);
        #1;
        tests_run++; if (instr_ready_o !== 1'b1) begin tests_failed++;
            $display("FAIL b2b_ready2: got %b exp 1", instr_ready_o); end
        tick();
        instr_valid_i = 1'b0;
        tests_run++; if (ex_imm_o !== 32'h1000 || ex_rd_o !== 5'd13 || ex_pc_o !== 32'h608) begin
            tests_failed++;
            $display("FAIL b2b_auipc: got imm=%h rd=%0d pc=%h exp 1000,13,608", ex_imm_o, ex_rd_o, ex_pc_o); end
        tick();
        tests_run++; if (ex_valid_o !== 1'b0) begin tests_failed++;
            $display("FAIL b2b_drain: got %b exp 0", ex_valid_o); end
    endtask

    // x1 and x13 are busy; an asynchronous reset must clear them at once.
    task automatic test_reset_mid();
        present(32'h40D087B3, 32'h700);
        #1;
        tests_run++; if (instr_ready_o !== 1'b0) begin tests_failed++;
            $display("FAIL rst_pre_stall: got %b exp 0", instr_ready_o); end
        tick();
        reset_n = 1'b0;
        #1;
        tests_run++; if (ex_valid_o !== 1'b0 || ex_pc_o !== 32'h0) begin tests_failed++;
            $display("FAIL rst_async: got v=%b pc=%h exp 0,0", ex_valid_o, ex_pc_o); end
        tick();
        reset_n = 1'b1;
        #1;
        tests_run++; if (instr_ready_o !== 1'b1) begin tests_failed++;
            $display("FAIL rst_busy_clr: got %b exp 1", instr_ready_o); end
        tick();
        instr_valid_i = 1'b0;
        tests_run++; if (ex_funct7b5_o !== 1'b1 || ex_rd_o !== 5'd15 || ex_imm_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL rst_sub: got f7=%b rd=%0d imm=%h exp 1,15,0", ex_funct7b5_o, ex_rd_o, ex_imm_o); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_raw();
        test_branch();
        test_backpressure();
        test_flush();
        test_illegal_x0();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
